// File: rtl/mips_cpu_ifetch.sv
// mips_cpu_ifetch: fetches one instruction word per PC over Avalon-MM and
// hands it to decode with valid/ready; flags misaligned PCs and bus timeouts.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   pc, pc_valid        fetch request from the PC unit
//   pc_ack              combinational: request accepted this cycle
//   avm_address/read    registered Avalon-MM read master outputs
//   avm_byteenable      always 4'hF (full-word reads)
//   avm_waitrequest     slave stall
//   avm_readdata        read data
//   instr, instr_pc     fetched word and the address it came from
//   instr_valid/ready   handshake towards decode
//   fetch_error         sticky error, cleared only by reset
module mips_cpu_ifetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int unsigned MAX_WAIT     = 255,
    parameter bit          SWAP_BYTES   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        pc_ack,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_error
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD,
        ERROR
    } state_t;

    localparam logic [7:0] MAX_WAIT8 = MAX_WAIT[7:0];

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_nxt;
    logic        aligned;
    logic        can_take;
    logic        accept;
    logic        misalign;
    logic [31:0] rdata_fmt;

    assign aligned  = (pc[1:0] == 2'b00);

    // A new request can be taken when nothing is in flight, or when the
    // held word is being consumed in this same cycle.
    assign can_take = (state == IDLE) ||
                      ((state == HOLD) && instr_ready);
    assign accept   = !reset && pc_valid && aligned && can_take;
    assign misalign = pc_valid && !aligned && can_take;

    assign pc_ack         = accept;
    assign avm_byteenable = 4'hF;

    // Saturating increment so a very long stall never wraps to zero.
    assign wait_nxt = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

    always_comb begin
        rdata_fmt = avm_readdata;
        if (SWAP_BYTES) begin
            rdata_fmt = {avm_readdata[7:0],
                         avm_readdata[15:8],
                         avm_readdata[23:16],
                         avm_readdata[31:24]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= RESET_VECTOR;
            instr       <= 32'h0;
            instr_pc    <= RESET_VECTOR;
            instr_valid <= 1'b0;
            fetch_error <= 1'b0;
            wait_cnt    <= 8'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        avm_address <= pc;
                        instr_pc    <= pc;
                        avm_read    <= 1'b1;
                        wait_cnt    <= 8'h0;
                        state       <= READ;
                    end else if (misalign) begin
                        fetch_error <= 1'b1;
                        state       <= ERROR;
                    end
                end
                READ: begin
                    if (!avm_waitrequest) begin
                        instr       <= rdata_fmt;
                        avm_read    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        wait_cnt <= wait_nxt;
                        if ((MAX_WAIT != 0) &&
                            (wait_nxt == MAX_WAIT8)) begin
                            avm_read    <= 1'b0;
                            fetch_error <= 1'b1;
                            state       <= ERROR;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (accept) begin
                            avm_address <= pc;
                            instr_pc    <= pc;
                            avm_read    <= 1'b1;
                            wait_cnt    <= 8'h0;
                            state       <= READ;
                        end else if (misalign) begin
                            fetch_error <= 1'b1;
                            state       <= ERROR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ERROR: begin
                    avm_read    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// tb_mips_cpu_ifetch: scoreboard bench for mips_cpu_ifetch.
// Main instance uses defaults; a second instance covers timeout and byte swap.
module tb_mips_cpu_ifetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        reset, pc_valid, pc_ack, avm_read, avm_waitrequest;
    logic        instr_valid, instr_ready, fetch_error;
    logic [31:0] pc, avm_address, avm_readdata, instr, instr_pc;
    logic [3:0]  avm_byteenable;

    logic        b_reset, b_pc_valid, b_pc_ack, b_avm_read, b_wr;
    logic        b_iv, b_ready, b_err;
    logic [31:0] b_pc, b_addr, b_rd, b_instr, b_instr_pc;
    logic [3:0]  b_be;

    mips_cpu_ifetch dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid),
        .pc_ack(pc_ack), .avm_address(avm_address), .avm_read(avm_read),
        .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_error(fetch_error)
    );

    mips_cpu_ifetch #(.MAX_WAIT(4), .SWAP_BYTES(1'b1)) dut_b (
        .clk(clk), .reset(b_reset), .pc(b_pc), .pc_valid(b_pc_valid),
        .pc_ack(b_pc_ack), .avm_address(b_addr), .avm_read(b_avm_read),
        .avm_byteenable(b_be), .avm_waitrequest(b_wr),
        .avm_readdata(b_rd), .instr(b_instr), .instr_pc(b_instr_pc),
        .instr_valid(b_iv), .instr_ready(b_ready), .fetch_error(b_err)
    );

    int tests = 0;
    int fails = 0;
    int consumed = 0;
    bit mon_en = 1'b0;
    bit rand_ws = 1'b0;
    int fixed_ws = 0;

    logic [31:0] addr_q[$];
    logic [63:0] instr_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RV) return 32'h24020005;
        return (a ^ 32'hA5A50000) + {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Avalon slave for the main instance: a chosen number of wait states
    // per read, then data looked up from the memory model.
    initial begin
        bit started;
        int cnt, tgt;
        started = 0; cnt = 0; tgt = 0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'h0;
        forever begin
            tick();
            if (avm_read) begin
                if (!started) begin
                    started = 1;
                    cnt = 0;
                    tgt = rand_ws ? int'($urandom_range(0, 3)) : fixed_ws;
                end
                if (cnt < tgt) begin
                    avm_waitrequest = 1'b1;
                    cnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    started = 0;
                end
            end else begin
                started = 0;
                avm_waitrequest = rand_ws ? 1'($urandom) : 1'b0;
            end
            avm_readdata = mem_word(avm_address);
        end
    end

    // Monitor/scoreboard: one read in flight at a time, words delivered
    // in acceptance order, each matching the memory at its address.
    initial begin
        logic [63:0] e;
        bit exp_ack;
        forever begin
            @(negedge clk);
            if (reset) begin
                addr_q.delete();
                instr_q.delete();
            end else begin
                exp_ack = pc_valid && (pc[1:0] == 2'b00) &&
                          (addr_q.size() == 0) &&
                          ((instr_q.size() == 0) || instr_ready);
                if (mon_en) check("pc_ack", {31'h0, pc_ack},
                                  {31'h0, exp_ack});
                if (avm_read) begin
                    if (addr_q.size() == 0) flag("read_unrequested");
                    else begin
                        check("avm_address", avm_address, addr_q[0]);
                        if (!avm_waitrequest) void'(addr_q.pop_front());
                    end
                end
                if (instr_valid && instr_ready) begin
                    if (instr_q.size() == 0) flag("instr_unexpected");
                    else begin
                        e = instr_q.pop_front();
                        check("instr", instr, e[31:0]);
                        check("instr_pc", instr_pc, e[63:32]);
                        consumed++;
                    end
                end
                if (pc_ack) begin
                    addr_q.push_back(pc);
                    instr_q.push_back({pc, mem_word(pc)});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pc = RV; pc_valid = 1'b1; instr_ready = 1'b1;
        b_reset = 1'b1; b_pc = RV; b_pc_valid = 1'b0; b_ready = 1'b1;
        b_wr = 1'b0; b_rd = 32'h0;
        tick(); tick();
        #2;
        check("rst_ack", {31'h0, pc_ack}, 32'h0);
        check("rst_read", {31'h0, avm_read}, 32'h0);
        check("rst_addr", avm_address, RV);
        check("rst_instr", instr, 32'h0);
        check("rst_ipc", instr_pc, RV);
        check("rst_iv", {31'h0, instr_valid}, 32'h0);
        check("rst_err", {31'h0, fetch_error}, 32'h0);
        check("byteenable", {28'h0, avm_byteenable}, 32'hF);

        // Zero-wait fetch from the reset vector.
        reset = 1'b0; mon_en = 1'b1; fixed_ws = 0;
        #2 check("t1_ack", {31'h0, pc_ack}, 32'h1);
        tick(); pc_valid = 1'b0;
        #2 check("t1_read", {31'h0, avm_read}, 32'h1);
        check("t1_addr", avm_address, RV);
        tick();
        #2 check("t1_iv", {31'h0, instr_valid}, 32'h1);
        check("t1_instr", instr, 32'h24020005);
        check("t1_ipc", instr_pc, RV);
        tick();

        // Three wait states.
        fixed_ws = 3; pc = RV + 4; pc_valid = 1'b1;
        #2 check("t2_ack", {31'h0, pc_ack}, 32'h1);
        tick(); pc_valid = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2 check("t2_read", {31'h0, avm_read}, 32'h1);
            check("t2_addr", avm_address, RV + 4);
            check("t2_iv", {31'h0, instr_valid}, 32'h0);
            tick();
        end
        #2 check("t2_iv5", {31'h0, instr_valid}, 32'h1);

        // Decode stalls in HOLD with a request pending.
        pc = RV + 8; pc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("t3_ack", {31'h0, pc_ack}, 32'h0);
            check("t3_instr", instr, mem_word(RV + 4));
            check("t3_iv", {31'h0, instr_valid}, 32'h1);
            tick();
        end
        fixed_ws = 0; instr_ready = 1'b1;
        #2 check("t3_ack_go", {31'h0, pc_ack}, 32'h1);
        tick(); pc_valid = 1'b0;
        #2 check("t3_read", {31'h0, avm_read}, 32'h1);
        check("t3_addr", avm_address, RV + 8);
        tick(); tick();

        // Misaligned PC.
        mon_en = 1'b0; pc = RV + 2; pc_valid = 1'b1;
        #2 check("t4_ack", {31'h0, pc_ack}, 32'h0);
        tick(); pc = RV + 12;
        for (int i = 0; i < 4; i++) begin
            #2 check("t4_err", {31'h0, fetch_error}, 32'h1);
            check("t4_ack_err", {31'h0, pc_ack}, 32'h0);
            check("t4_read", {31'h0, avm_read}, 32'h0);
            check("t4_iv", {31'h0, instr_valid}, 32'h0);
            tick();
        end
        pc_valid = 1'b0; reset = 1'b1;
        tick();
        #2 check("t4_err_clr", {31'h0, fetch_error}, 32'h0);

        // Reset during the second wait cycle of a read.
        reset = 1'b0; mon_en = 1'b1; fixed_ws = 5;
        pc = RV + 16; pc_valid = 1'b1;
        tick(); pc_valid = 1'b0;
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; fixed_ws = 0;
        #2 check("t6_read", {31'h0, avm_read}, 32'h0);
        check("t6_iv", {31'h0, instr_valid}, 32'h0);
        check("t6_addr", avm_address, RV);
        tick();
        pc = RV + 32; pc_valid = 1'b1;
        #2 check("t6_ack", {31'h0, pc_ack}, 32'h1);
        tick(); pc_valid = 1'b0;
        tick();
        #2 check("t6_iv2", {31'h0, instr_valid}, 32'h1);
        check("t6_instr", instr, mem_word(RV + 32));
        tick();

        // Randomized traffic.
        rand_ws = 1'b1;
        for (int i = 0; i < 600; i++) begin
            pc = {$urandom, 2'b00} >> 0;
            pc[1:0] = 2'b00;
            pc_valid = 1'($urandom);
            instr_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        pc_valid = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 50 && (addr_q.size() != 0 ||
                                  instr_q.size() != 0); i++) tick();
        check("drain_addr", addr_q.size(), 32'h0);
        check("drain_instr", instr_q.size(), 32'h0);
        tests++;
        if (consumed < 60) begin
            fails++;
            $display("FAIL throughput: got %0d, expected >= 60", consumed);
        end

        // Second instance: byte swap, then watchdog timeout.
        b_reset = 1'b0; b_pc = RV; b_pc_valid = 1'b1;
        b_rd = 32'h11223344;
        #2 check("b_ack", {31'h0, b_pc_ack}, 32'h1);
        tick(); b_pc_valid = 1'b0;
        #2 check("b_read", {31'h0, b_avm_read}, 32'h1);
        tick();
        #2 check("b_swap", b_instr, 32'h44332211);
        check("b_iv", {31'h0, b_iv}, 32'h1);
        check("b_be", {28'h0, b_be}, 32'hF);
        tick();
        b_pc = RV + 64; b_pc_valid = 1'b1; b_wr = 1'b1;
        #2 check("b_ack2", {31'h0, b_pc_ack}, 32'h1);
        tick(); b_pc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2 check("b_wait_read", {31'h0, b_avm_read}, 32'h1);
            check("b_wait_err", {31'h0, b_err}, 32'h0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            #2 check("b_to_err", {31'h0, b_err}, 32'h1);
            check("b_to_read", {31'h0, b_avm_read}, 32'h0);
            check("b_to_iv", {31'h0, b_iv}, 32'h0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_cpu_ifetch.md
# mips_cpu_ifetch

Instruction-fetch responder for the MIPS CPU. It takes fetch addresses from the program-counter unit, performs a single-word Avalon-MM read per address, and presents the returned instruction word to decode with a valid/ready handshake. It also acknowledges each accepted address so the PC unit can advance, and raises a sticky error on a misaligned PC or a bus timeout.

## Interface
Parameters:
- RESET_VECTOR, 32'hBFC00000, value of avm_address and instr_pc after reset
- MAX_WAIT, 255, waitrequest cycles tolerated per read before timeout; 0 disables the watchdog
- SWAP_BYTES, 0, when 1 instr = byte-reversed avm_readdata, else unchanged

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc  in  32  fetch address from PC unit
- pc_valid  in  1  pc holds a fetch request
- pc_ack  out  1  combinational; request accepted this cycle
- avm_address  out  32  registered word address
- avm_read  out  1  registered read strobe
- avm_byteenable  out  4  constant 4'hF
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data, valid when avm_read=1 and avm_waitrequest=0
- instr  out  32  fetched instruction word
- instr_pc  out  32  address instr was fetched from
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decode consumes instr when instr_valid=1
- fetch_error  out  1  sticky; set on misaligned pc or timeout

## Operation
- States: IDLE, READ, HOLD, ERROR. Reset enters IDLE.
- Accept condition: pc_valid=1, pc[1:0]=0, and (state=IDLE, or state=HOLD with instr_ready=1). pc_ack = accept condition.
- IDLE: on accept, latch pc into avm_address and instr_pc, set avm_read=1, reset wait counter, go READ. pc_valid=1 with pc[1:0]!=0 -> ERROR.
- READ: avm_read=1; avm_address stable. If avm_waitrequest=0: capture instr (swapped per SWAP_BYTES), avm_read<=0, instr_valid<=1, go HOLD. Else increment wait counter. If MAX_WAIT!=0 and the counter reaches MAX_WAIT: avm_read<=0, go ERROR.
- HOLD: instr_valid=1; instr and instr_pc stable until consumed. With instr_ready=1: on accept, go READ with the new address and instr_valid<=0. Without accept, go IDLE with instr_valid<=0. A misaligned pc with instr_ready=1 -> ERROR. With instr_ready=0: hold state, pc_ack=0.
- ERROR: fetch_error=1, avm_read=0, instr_valid=0, pc_ack=0. Exit only via reset.
- Wait counter is 8 bits wide. It saturates and never wraps; the comparison uses MAX_WAIT[7:0].

## Timing
- Reset values: avm_read=0, avm_address=RESET_VECTOR, instr=0, instr_pc=RESET_VECTOR, instr_valid=0, fetch_error=0, wait counter=0. pc_ack=0 while reset=1.
- Reset while in READ: avm_read=0 from the following cycle. The outstanding read is abandoned and its data ignored.
- Latency: pc accepted at edge N -> avm_read=1 in cycle N+1. With zero wait states, instr_valid=1 in cycle N+2.
- Each wait state adds 1 cycle.
- Peak throughput: 1 instruction per 2 cycles, with back-to-back accept in HOLD.
- avm_read is never asserted for two different addresses without an intervening data return.
- fetch_error rises the cycle after the detecting edge.
- Timeout: with MAX_WAIT=M, fetch_error=1 in the cycle after the M-th consecutive waitrequest=1 cycle of a read.

## Test plan
- Reset, pc=32'hBFC00000, pc_valid=1, waitrequest=0, readdata=32'h24020005, instr_ready=1. Required: pc_ack=1 in cycle 0; avm_read=1 with address BFC00000 in cycle 1; instr=24020005, instr_pc=BFC00000, instr_valid=1 in cycle 2.
- 3 wait states on address BFC00004. Required: avm_read held 4 cycles with the address stable; instr_valid 5 cycles after accept.
- instr_ready=0 for 4 cycles in HOLD with pc_valid=1. Required: pc_ack=0 and instr stable for all 4 cycles. On instr_ready=1, pc_ack=1 and the next read issues in the following cycle.
- pc=32'hBFC00002, pc_valid=1. Required: pc_ack=0, no read issued, fetch_error=1 next cycle and held until reset.
- MAX_WAIT=4 with waitrequest stuck at 1. Required: avm_read drops and fetch_error=1 after 4 wait cycles; instr_valid never rises.
- Reset asserted in the second wait cycle of a read. Required: avm_read=0, instr_valid=0, avm_address=BFC00000 the next cycle; a following fetch completes normally.
